// File: rtl/wiener_fetch_scheduler.sv
// Raster fetch controller: streams each 320x240 source row from ROM one row ahead of display,
// tags returned pixels with col/row, and drives line-buffer rotate and edge-replication flags.
module wiener_fetch_scheduler #(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int ROM_LAT = 1,
  parameter int AW      = 17
) (
  input  logic          i_pclk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_frame_start,
  input  logic          i_line_start,
  input  logic [8:0]    i_vga_y,
  output logic          o_rom_en,
  output logic [AW-1:0] o_rom_addr,
  output logic          o_wr_valid,
  output logic [8:0]    o_wr_col,
  output logic [7:0]    o_wr_row,
  output logic          o_row_done,
  output logic          o_lb_rotate,
  output logic          o_frame_ready,
  output logic          o_edge_top,
  output logic          o_edge_bot,
  output logic          o_busy,
  output logic          o_err_overrun,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME0    = 3'd1,
    PRIME1    = 3'd2,
    WAIT_LINE = 3'd3,
    FETCH     = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t        r_state, w_state_d;
  // Tag of the burst in flight: PRIME0, PRIME1 or WAIT_LINE (steady state).
  state_t        r_tag, w_tag_d;
  logic          r_rom_en;
  logic [AW-1:0] r_rom_addr;
  logic [8:0]    r_col;
  logic [7:0]    r_cur_row;
  logic [1:0]    r_dcnt;
  logic [AW-1:0] r_row_base;
  logic [7:0]    r_next_row;
  logic          r_pv   [ROM_LAT];
  logic [8:0]    r_pcol [ROM_LAT];
  logic [7:0]    r_prow [ROM_LAT];
  logic          r_row_done, r_lb_rotate, r_frame_ready;
  logic          r_edge_top, r_edge_bot, r_err_overrun;

  logic          w_launch, w_restart, w_abort, w_row_end, w_service, w_overrun;
  logic [7:0]    w_disp;
  logic          w_line_ok, w_fetchable, w_last_col, w_drain_end;

  assign w_disp      = i_vga_y[8:1];
  assign w_line_ok   = i_line_start && !i_vga_y[0] && (i_vga_y < 9'd480);
  assign w_fetchable = ({1'b0, w_disp} + 9'd2) <= 9'(SRC_H - 1);
  assign w_last_col  = (r_col == 9'(SRC_W - 1));
  assign w_drain_end = (r_dcnt == 2'(ROM_LAT - 1));
  assign w_overrun   = i_line_start && ((r_state == FETCH) || (r_state == DRAIN));

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_tag_d   = r_tag;
    w_launch  = 1'b0;
    w_restart = 1'b0;
    w_abort   = 1'b0;
    w_row_end = 1'b0;
    w_service = 1'b0;
    if (i_frame_start && (r_state != IDLE) && (r_state != DONE)) begin
      // Resync: drop everything in flight and restart the frame from row 0.
      w_abort = 1'b1;
      if (i_enable) begin
        w_state_d = FETCH;
        w_tag_d   = PRIME0;
        w_launch  = 1'b1;
        w_restart = 1'b1;
      end else begin
        w_state_d = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_frame_start && i_enable) begin
            w_state_d = FETCH;
            w_tag_d   = PRIME0;
            w_launch  = 1'b1;
            w_restart = 1'b1;
          end
        end
        PRIME1: begin
          w_state_d = FETCH;
          w_tag_d   = PRIME1;
          w_launch  = 1'b1;
        end
        WAIT_LINE: begin
          if (w_line_ok) begin
            w_service = 1'b1;
            if (i_vga_y == 9'd478) begin
              w_state_d = DONE;
            end else if (w_fetchable) begin
              w_state_d = FETCH;
              w_tag_d   = WAIT_LINE;
              w_launch  = 1'b1;
            end
          end
        end
        FETCH: begin
          if (w_last_col) w_state_d = DRAIN;
        end
        DRAIN: begin
          if (w_drain_end) begin
            w_row_end = 1'b1;
            w_state_d = (r_tag == PRIME0) ? PRIME1 : WAIT_LINE;
          end
        end
        DONE: begin
          if (i_frame_start) w_state_d = IDLE;
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag         <= IDLE;
      r_rom_en      <= 1'b0;
      r_rom_addr    <= '0;
      r_col         <= '0;
      r_cur_row     <= '0;
      r_dcnt        <= '0;
      r_row_base    <= '0;
      r_next_row    <= '0;
      r_row_done    <= 1'b0;
      r_lb_rotate   <= 1'b0;
      r_frame_ready <= 1'b0;
      r_edge_top    <= 1'b0;
      r_edge_bot    <= 1'b0;
      r_err_overrun <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pv[i]   <= 1'b0;
        r_pcol[i] <= '0;
        r_prow[i] <= '0;
      end
    end else begin
      r_row_done  <= w_row_end;
      r_lb_rotate <= w_row_end;
      // ROM data pipeline: the abort kills every read still in flight.
      r_pv[0]   <= r_rom_en && !w_abort;
      r_pcol[0] <= r_col;
      r_prow[0] <= r_cur_row;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1] && !w_abort;
        r_pcol[i] <= r_pcol[i-1];
        r_prow[i] <= r_prow[i-1];
      end
      if (w_overrun) r_err_overrun <= 1'b1;
      if (w_abort) begin
        r_rom_en   <= 1'b0;
        r_edge_top <= 1'b0;
        r_edge_bot <= 1'b0;
      end
      if (w_restart) begin
        r_row_base <= '0;
        r_next_row <= '0;
      end
      if (w_launch) begin
        r_rom_en   <= 1'b1;
        r_rom_addr <= w_restart ? '0 : r_row_base;
        r_col      <= '0;
        r_cur_row  <= w_restart ? 8'd0 : r_next_row;
        r_tag      <= w_tag_d;
      end else if ((r_state == FETCH) && !w_abort) begin
        if (w_last_col) begin
          r_rom_en <= 1'b0;
          r_dcnt   <= '0;
        end else begin
          r_col      <= r_col + 9'd1;
          r_rom_addr <= r_rom_addr + AW'(1);
        end
      end else if ((r_state == DRAIN) && !w_abort) begin
        r_dcnt <= r_dcnt + 2'd1;
      end
      if (w_row_end) begin
        r_row_base <= r_row_base + AW'(SRC_W);
        r_next_row <= r_next_row + 8'd1;
      end
      if (w_service) begin
        r_edge_top <= (w_disp == 8'd0);
        r_edge_bot <= (w_disp == 8'(SRC_H - 1));
      end
      if ((w_state_d == IDLE) || w_abort) r_frame_ready <= 1'b0;
      else if (w_row_end && (r_tag == PRIME1)) r_frame_ready <= 1'b1;
    end
  end

  // wr_valid qualifies wr_col/wr_row; there is no back-pressure, the consumer must accept every beat.
  assign o_rom_en      = r_rom_en;
  assign o_rom_addr    = r_rom_addr;
  assign o_wr_valid    = r_pv[ROM_LAT-1];
  assign o_wr_col      = r_pcol[ROM_LAT-1];
  assign o_wr_row      = r_prow[ROM_LAT-1];
  assign o_row_done    = r_row_done;
  assign o_lb_rotate   = r_lb_rotate;
  assign o_frame_ready = r_frame_ready;
  assign o_edge_top    = r_edge_top;
  assign o_edge_bot    = r_edge_bot;
  assign o_busy        = (r_state == FETCH) || (r_state == DRAIN);
  assign o_err_overrun = r_err_overrun;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_wiener_fetch_scheduler.sv
// Scoreboard bench for wiener_fetch_scheduler: directed frame/line stimulus pushes expected
// addresses, tagged pixels and row_done events; a negedge monitor pops and compares them.
module tb_wiener_fetch_scheduler;
  localparam int SRC_W = 320;
  localparam int SRC_H = 240;
  localparam int AW    = 17;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd3, ST_DONE = 3'd6;

  logic          clk = 1'b0;
  logic          rst_n, enable, frame_start, line_start;
  logic [8:0]    vga_y;
  logic          rom_en, wr_valid, row_done, lb_rotate, frame_ready;
  logic          edge_top, edge_bot, busy, err_overrun;
  logic [AW-1:0] rom_addr;
  logic [8:0]    wr_col;
  logic [7:0]    wr_row;
  logic [2:0]    dbg_state;

  logic [AW-1:0] addr_q[$];
  logic [16:0]   exp_q[$];
  logic [7:0]    rd_q[$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_wr = 0;
  logic [7:0] last_row = '0;
  bit  mon_on = 1'b0;

  wiener_fetch_scheduler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ROM_LAT(1), .AW(AW)) dut (
    .i_pclk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_frame_start(frame_start),
    .i_line_start(line_start), .i_vga_y(vga_y), .o_rom_en(rom_en), .o_rom_addr(rom_addr),
    .o_wr_valid(wr_valid), .o_wr_col(wr_col), .o_wr_row(wr_row), .o_row_done(row_done),
    .o_lb_rotate(lb_rotate), .o_frame_ready(frame_ready), .o_edge_top(edge_top),
    .o_edge_bot(edge_bot), .o_busy(busy), .o_err_overrun(err_overrun), .o_dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_frame(input bit en);
    enable = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_line(input int y);
    vga_y = 9'(y);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic push_row(input int row, input int n_addr, input int n_wr, input bit done);
    for (int c = 0; c < n_addr; c++) addr_q.push_back(AW'(row * SRC_W + c));
    for (int c = 0; c < n_wr; c++)   exp_q.push_back({8'(row), 9'(c)});
    if (done) rd_q.push_back(8'(row));
  endtask

  task automatic wait_busy_low(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!frame_ready && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(frame_ready), 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (rom_en) begin
        if (addr_q.size() == 0) miss("rom_en_unexpected");
        else check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
      end
      if (wr_valid) begin
        if (exp_q.size() == 0) miss("wr_valid_unexpected");
        else check("wr_row_col", 32'({wr_row, wr_col}), 32'(exp_q.pop_front()));
        last_wr  = cyc;
        last_row = wr_row;
      end
      if (row_done || lb_rotate) begin
        check("lb_rotate_vs_row_done", 32'(lb_rotate), 32'(row_done));
        if (rd_q.size() == 0) miss("row_done_unexpected");
        else begin
          check("row_done_row", 32'(last_row), 32'(rd_q.pop_front()));
          check("row_done_gap", 32'(cyc - last_wr), 32'd1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; line_start = 1'b0; vga_y = '0;
    ticks(3);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Async reset in the middle of a burst, with a sticky overrun pending
    pulse_frame(1'b1);
    ticks(20);
    check("busy_in_fetch", 32'(busy), 1);
    pulse_line(1);
    check("overrun_before_reset", 32'(err_overrun), 1);
    ticks(10);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_rom_en", 32'(rom_en), 0);
    check("async_rst_wr_valid", 32'(wr_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_frame_ready", 32'(frame_ready), 0);
    check("async_rst_overrun", 32'(err_overrun), 0);
    ticks(2);
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;

    // Priming: rows 0 and 1, frame_ready with the second row_done
    push_row(0, SRC_W, SRC_W, 1'b1);
    push_row(1, SRC_W, SRC_W, 1'b1);
    pulse_frame(1'b1);
    check("first_rom_en", 32'(rom_en), 1);
    ticks(642);
    check("frame_ready_early", 32'(frame_ready), 0);
    check("prime1_drain_busy", 32'(busy), 1);
    tick();
    check("prime1_row_done", 32'(row_done), 1);
    check("frame_ready_rise", 32'(frame_ready), 1);
    check("wait_line_busy", 32'(busy), 0);

    // Steady state: vga_y=0 fetches row 2, vga_y=1 does nothing
    push_row(2, SRC_W, SRC_W, 1'b1);
    pulse_line(0);
    check("edge_top_y0", 32'(edge_top), 1);
    check("edge_bot_y0", 32'(edge_bot), 0);
    wait_busy_low("row2_timeout");
    pulse_line(1);
    ticks(5);
    check("odd_line_rom_en", 32'(rom_en), 0);
    check("odd_line_busy", 32'(busy), 0);

    // Overrun: a line_start 100 cycles into a burst
    push_row(3, SRC_W, SRC_W, 1'b1);
    pulse_line(2);
    check("edge_top_y2", 32'(edge_top), 0);
    ticks(99);
    pulse_line(3);
    check("overrun_set", 32'(err_overrun), 1);
    wait_busy_low("row3_timeout");
    ticks(2);
    check("overrun_sticky", 32'(err_overrun), 1);

    // Rows 4..238 at vga_y 4..472
    for (int y = 4; y <= 472; y += 2) begin
      push_row(y / 2 + 2, SRC_W, SRC_W, 1'b1);
      pulse_line(y);
      wait_busy_low("steady_row_timeout");
    end

    // Bottom edge
    push_row(239, SRC_W, SRC_W, 1'b1);
    pulse_line(474);
    check("edge_bot_y474", 32'(edge_bot), 0);
    wait_busy_low("row239_timeout");
    pulse_line(476);
    ticks(4);
    check("y476_rom_en", 32'(rom_en), 0);
    check("y476_edge_bot", 32'(edge_bot), 0);
    check("y476_state", 32'(dbg_state), 32'(ST_WAIT));
    pulse_line(478);
    check("y478_edge_bot", 32'(edge_bot), 1);
    check("y478_state", 32'(dbg_state), 32'(ST_DONE));
    ticks(4);
    check("done_rom_en", 32'(rom_en), 0);

    // DONE returns to IDLE on frame_start
    pulse_frame(1'b1);
    check("done_to_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("idle_frame_ready", 32'(frame_ready), 0);
    ticks(3);
    check("idle_busy", 32'(busy), 0);

    // Resync at col 150 of a steady burst
    push_row(0, SRC_W, SRC_W, 1'b1);
    push_row(1, SRC_W, SRC_W, 1'b1);
    pulse_frame(1'b1);
    wait_ready("reprime_timeout");
    ticks(2);
    push_row(2, 151, 150, 1'b0);
    push_row(0, SRC_W, SRC_W, 1'b1);
    pulse_line(0);
    ticks(150);
    pulse_frame(1'b1);
    check("resync_rom_en", 32'(rom_en), 1);
    check("resync_rom_addr", 32'(rom_addr), 0);
    check("resync_wr_valid", 32'(wr_valid), 0);
    check("resync_edge_top", 32'(edge_top), 0);
    check("resync_frame_ready", 32'(frame_ready), 0);
    push_row(1, SRC_W, SRC_W, 1'b1);
    wait_ready("resync_prime_timeout");
    ticks(2);

    // enable=0: the next frame_start parks the block in IDLE
    pulse_frame(1'b0);
    check("disable_state", 32'(dbg_state), 32'(ST_IDLE));
    check("disable_frame_ready", 32'(frame_ready), 0);
    ticks(5);
    check("disable_rom_en", 32'(rom_en), 0);

    check("addr_q_empty", 32'(addr_q.size()), 0);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("rd_q_empty", 32'(rd_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
